// File: rtl/write_stage_pkg.sv
// write_stage_pkg: shared pipeline types, register-file layout and write-stage FSM encoding
package write_stage_pkg;
  localparam int NR = 4;
  localparam int Flags = NR - 1;
  localparam int PC = Flags - 1;
  typedef logic [31:0] regval_t;
  typedef logic [3:0] regind_t;
  typedef logic [3:0] flags_t;
  typedef regval_t [NR-1:0] regfile_t;
  localparam regfile_t ZeroRegFile = '0;
  typedef enum logic {IDLE, STORE} write_state_t;
  // Architectural view: r0 hard-wired to zero, PC slot owned by fetch
  function automatic regfile_t subst_in(regval_t pc, regfile_t rf);
    subst_in = rf;
    subst_in[0] = '0;
    subst_in[PC] = pc;
  endfunction
endpackage

// File: rtl/write_stage_if.sv
// write_stage_if: pipeline handshake, retire, redirect and bypass interfaces
interface i_flow_control;
  logic is_valid;
  logic hold;
  modport in (input is_valid, output hold);
  modport out (output is_valid, input hold);
endinterface

interface i_execute_to_write;
  import write_stage_pkg::*;
  logic has_flushed;
  logic is_writing_memory;
  regind_t destination_register;
  regval_t destination_value;
  regval_t adjustment_value;
  logic has_upper_value;
  regval_t upper_value;
  flags_t flags;
  modport write_in (input has_flushed, is_writing_memory, destination_register, destination_value,
                    adjustment_value, has_upper_value, upper_value, flags);
  modport execute_out (output has_flushed, is_writing_memory, destination_register, destination_value,
                       adjustment_value, has_upper_value, upper_value, flags);
endinterface

interface i_write_to_fetch;
  import write_stage_pkg::*;
  regval_t next_pc;
  logic has_flushed;
  modport write_out (input next_pc, output has_flushed);
  modport fetch_in (output next_pc, input has_flushed);
endinterface

interface i_feedback;
  import write_stage_pkg::*;
  logic is_valid;
  regval_t value;
  regind_t index;
  regval_t upper_value;
  logic has_upper_value;
  modport out (output is_valid, value, index, upper_value, has_upper_value);
  modport in (input is_valid, value, index, upper_value, has_upper_value);
endinterface

// File: rtl/write_stage_register_file.sv
// register_file: architectural register storage with dual (d, d+1) write port and flags merge
module register_file
  import write_stage_pkg::*;
(
  input  logic     clock,
  input  logic     reset_n,
  input  logic     we,
  input  regind_t  d,
  input  regval_t  value,
  input  logic     has_upper,
  input  regval_t  upper,
  input  flags_t   flags,
  input  regval_t  next_pc,
  output regfile_t registers
);
  regfile_t stored_q, stored_d;
  // Flags default first so an explicit write to the Flags slot overrides it; PC slot never stored
  always_comb begin
    stored_d = stored_q;
    if (we) begin
      stored_d[Flags] = regval_t'(flags);
      for (int i = 1; i < NR; i++) begin
        if (i != PC && int'(d) == i) stored_d[i] = value;
        if (i != PC && has_upper && d != '0 && int'(d) + 1 == i) stored_d[i] = upper;
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) stored_q <= ZeroRegFile;
    else stored_q <= stored_d;
  assign registers = subst_in(next_pc, stored_q);
endmodule

// File: rtl/write_stage.sv
// write_stage: retires instructions, commits registers/flags, runs the store handshake and redirects fetch
module write_stage
  import write_stage_pkg::*;
#(
  parameter regval_t RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  i_flow_control.in                  flow,
  i_execute_to_write.write_in        from_execute,
  i_write_to_fetch.write_out         to_fetch,
  i_feedback.out                     feedback,
  output regfile_t                   registers,
  output regval_t                    redirect_pc,
  output regval_t                    mem_address,
  output regval_t                    mem_data,
  output logic                       mem_write,
  input  logic                       mem_ready
);
  write_state_t state_q, state_d;
  logic flushed_q, flushed_d;
  regval_t redirect_q, redirect_d, addr_q, addr_d, data_q, data_d;
  logic accept, live, st, wr, pc_lo, pc_hi;
  regind_t d;
  always_comb begin
    d = from_execute.destination_register;
    accept = flow.is_valid && !flow.hold && state_q == IDLE;
    live = accept && !from_execute.has_flushed;
    st = live && from_execute.is_writing_memory;
    wr = live && !from_execute.is_writing_memory;
    pc_lo = wr && int'(d) == PC;
    pc_hi = wr && from_execute.has_upper_value && d != '0 && int'(d) + 1 == PC;
    state_d = state_q == IDLE ? (st ? STORE : IDLE) : (mem_ready ? IDLE : STORE);
    flushed_d = pc_lo || pc_hi;
    redirect_d = pc_lo ? from_execute.destination_value : pc_hi ? from_execute.upper_value : redirect_q;
    addr_d = st ? from_execute.adjustment_value : addr_q;
    data_d = st ? from_execute.destination_value : data_q;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      flushed_q <= 1'b0;
      redirect_q <= RESET_PC;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      flushed_q <= flushed_d;
      redirect_q <= redirect_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  register_file u_rf (
    .clock,
    .reset_n,
    .we(wr),
    .d,
    .value(from_execute.destination_value),
    .has_upper(from_execute.has_upper_value),
    .upper(from_execute.upper_value),
    .flags(from_execute.flags),
    .next_pc(to_fetch.next_pc),
    .registers
  );
  assign flow.hold = state_q == STORE;
  assign mem_write = state_q == STORE;
  assign mem_address = addr_q;
  assign mem_data = data_q;
  assign redirect_pc = redirect_q;
  assign to_fetch.has_flushed = flushed_q;
  assign feedback.is_valid = wr;
  assign feedback.value = from_execute.destination_value;
  assign feedback.index = d;
  assign feedback.upper_value = from_execute.upper_value;
  assign feedback.has_upper_value = from_execute.has_upper_value;
endmodule

// File: doc/write_stage.md
# write_stage

Final pipeline stage: retires instructions arriving on `i_execute_to_write` and holds the architectural register file. Commits register and flags results, drives one-word memory stores through a handshake, and back-pressures execute through `i_flow_control`. Publishes same-cycle bypass data on `i_feedback` and signals redirects to fetch on `i_write_to_fetch`.

## Interface
- `RESET_PC`, default 0: value of `redirect_pc` at reset.
- Shared package constants used unchanged: `NR` = 4, `Flags` = NR-1, `PC` = Flags-1.
- `clock`  in  1  stage clock; all state updates on its rising edge.
- `reset_n`  in  1  reset; one clock, asynchronous and active-low.
- `flow`  modport `i_flow_control.in`  -  `is_valid` from execute; `hold` to execute.
- `from_execute`  modport `i_execute_to_write.write_in`  -  retiring instruction.
- `to_fetch`  modport `i_write_to_fetch.write_out`  -  `next_pc` in (fetch's current PC); `has_flushed` out.
- `feedback`  modport `i_feedback.out`  -  bypass of the retiring register write.
- `registers`  out  regfile_t  architectural registers, formed as `subst_in(to_fetch.next_pc, stored)`.
- `redirect_pc`  out  32  target PC; valid while `has_flushed`=1.
- `mem_address`  out  32  store address.
- `mem_data`  out  32  store data.
- `mem_write`  out  1  store request.
- `mem_ready`  in  1  memory accepted the store.

## Operation
- Accept: `accept = flow.is_valid && !flow.hold && state==IDLE`.
- Annulled (`from_execute.has_flushed`=1) accepted instruction: no register, flags, store or redirect effect.
- Store (`is_writing_memory`=1): capture `mem_address` = `adjustment_value` and `mem_data` = `destination_value`, then go to STORE.
  - A store does not write registers or flags.
- Register write (`is_writing_memory`=0):
  - If d = `destination_register`, d≠0 and d<NR, then `stored[d] <= destination_value`.
  - If `has_upper_value`=1, d≠0 and d+1<NR, then `stored[d+1] <= upper_value`.
  - Indices ≥ NR are ignored.
- Flags: `stored[Flags] <= flags` on every accepted non-annulled non-store instruction, unless the instruction explicitly writes `Flags`; the explicit write wins.
- PC writes: a write to index PC (lower or upper slot) is not kept in the register file.
  - Next edge: `has_flushed`=1 for exactly one cycle.
  - `redirect_pc` takes the written value.
- Feedback (combinational): on an accepted register write, `feedback.is_valid`=1 and `value`/`index`/`upper_value`/`has_upper_value` mirror `from_execute`. Otherwise `is_valid`=0.
- FSM states:
  - IDLE→STORE on an accepted non-annulled store.
  - STORE→IDLE on an edge with `mem_ready`=1.
  - STORE→STORE otherwise.
- `hold` = (state==STORE). `mem_write` = (state==STORE).
- Reset values: state IDLE; `stored` all 0; `hold`=0, `mem_write`=0, `has_flushed`=0; `redirect_pc`=RESET_PC; `mem_address`=0, `mem_data`=0.
- Reset mid-STORE abandons the store: `mem_write` falls asynchronously.
- `registers[0]` always reads 0. `registers[PC]` always equals `to_fetch.next_pc`.

## Timing
- Register write: visible on `registers` the cycle after the accept edge; visible on `feedback` in the accept cycle itself.
- Redirect: `has_flushed` and `redirect_pc` valid one cycle after the accept edge; pulse width exactly 1 cycle.
- Store:
  - `mem_write` rises after the accept edge and stays high until the first edge that samples `mem_ready`=1.
  - Minimum STORE occupancy is 1 cycle. A `mem_ready` already high on entry completes at the next edge.
- After a store completes, the next accept is possible in the cycle after the return to IDLE. Every store therefore costs at least one bubble.
- `mem_address` and `mem_data` are stable for the whole of STORE.
- Non-store instructions can be accepted back-to-back every cycle.

## Structure
- Shared package (with the existing pipeline types): `regval_t`, `regind_t`, `regfile_t`, `NR`, `Flags`, `PC`, `ZeroRegFile`, `subst_in`, and the FSM enum `write_state_t` {IDLE, STORE}.
- Interfaces remain in the shared interface file.
- One sub-module, `register_file`: stored array, dual write port (d, d+1), flags-merge rule, and the `subst_in` output.
- The store FSM, feedback, and redirect logic stay in `write_stage`.

## Test plan
- Write d=1 with value 0x12345678, flags=4'b0101 → `feedback.is_valid`=1 in the same cycle; next cycle `registers[1]`=0x12345678 and `registers[Flags]`=5.
- d=1 with `has_upper_value`, value 0xA and upper 0xB → `registers[1]`=0xA, `registers[2]` unchanged (PC slot shows `next_pc`=0x40), `has_flushed` pulses 1 cycle, `redirect_pc`=0xB.
- Store with address 0x100 and data 0xDEAD, `mem_ready` low for 3 cycles → `mem_write` and `hold` high for 4 cycles; a second valid instruction is accepted only after the return to IDLE; registers unchanged.
- Annulled store and annulled d=3 write → no `mem_write`, no register or flags change, no `has_flushed`, `feedback.is_valid`=0.
- Write d=0 with value 0xFFFFFFFF → `registers[0]`=0; flags still updated.
- Assert `reset_n`=0 mid-STORE → `mem_write`, `hold`, `has_flushed` drop immediately; registers return to 0; `redirect_pc`=RESET_PC.
